// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-requester arbiter and pass sequencer for the shared 16-bit barrel shifter.
// Optional build macro SHIFTER_ARB_FIXED_PRIORITY_EN: requester 0 always wins a tie.
module shifter_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0Valid,
    output logic        Req0Ready,
    input  logic [2:0]  Req0Select,
    input  logic [4:0]  Req0Amount,
    input  logic [15:0] Req0Data,
    input  logic        Req1Valid,
    output logic        Req1Ready,
    input  logic [2:0]  Req1Select,
    input  logic [4:0]  Req1Amount,
    input  logic [15:0] Req1Data,
    output logic        Rsp0Valid,
    input  logic        Rsp0Ready,
    output logic [15:0] Rsp0Data,
    output logic        Rsp1Valid,
    input  logic        Rsp1Ready,
    output logic [15:0] Rsp1Data,
    output logic [2:0]  ShiftSelect,
    output logic [3:0]  ShifterAmount,
    output logic [15:0] OriginB,
    input  logic [15:0] ShiftedB,
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} stateT;

    stateT       state;
    stateT       nextState;
    logic [2:0]  opSel;
    logic [4:0]  remaining;
    logic [15:0] work;
    logic        owner;
    logic        lastGrant;

    logic        anyValid;
    logic        grant;
    logic        accept;
    logic [2:0]  reqSelect;
    logic [4:0]  reqAmount;
    logic [15:0] reqData;
    logic [3:0]  step;
    logic [4:0]  remainingNext;

    // The shifter handles at most 15 positions per pass.
    function automatic logic [3:0] passStep(input logic [4:0] rem);
        return (rem > 5'd15) ? 4'd15 : rem[3:0];
    endfunction

    always_comb begin
        anyValid = Req0Valid | Req1Valid;
`ifdef SHIFTER_ARB_FIXED_PRIORITY_EN
        grant = ~Req0Valid;
`else
        if (Req0Valid && Req1Valid) begin
            grant = ~lastGrant;
        end else begin
            grant = ~Req0Valid;
        end
`endif
        accept    = (state == IDLE) && anyValid && !Reset;
        reqSelect = grant ? Req1Select : Req0Select;
        reqAmount = grant ? Req1Amount : Req0Amount;
        reqData   = grant ? Req1Data : Req0Data;
        step          = passStep(remaining);
        remainingNext = remaining - {1'b0, step};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        Req0Ready     = 1'b0;
        Req1Ready     = 1'b0;
        Rsp0Valid     = 1'b0;
        Rsp1Valid     = 1'b0;
        Rsp0Data      = 16'h0;
        Rsp1Data      = 16'h0;
        ShiftSelect   = 3'd0;
        ShifterAmount = 4'd0;
        OriginB       = 16'h0;
        Busy          = (state != IDLE);
        case (state)
            IDLE: begin
                Req0Ready = accept && !grant;
                Req1Ready = accept && grant;
                if (accept) begin
                    nextState = (reqAmount == 5'd0) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                ShiftSelect   = opSel;
                ShifterAmount = step;
                OriginB       = work;
                if (remainingNext == 5'd0) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                // Ready on the non-owner channel is deliberately ignored.
                if (owner) begin
                    Rsp1Valid = 1'b1;
                    Rsp1Data  = work;
                    if (Rsp1Ready) begin
                        nextState = IDLE;
                    end
                end else begin
                    Rsp0Valid = 1'b1;
                    Rsp0Data  = work;
                    if (Rsp0Ready) begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            opSel     <= 3'd0;
            remaining <= 5'd0;
            work      <= 16'h0;
            owner     <= 1'b0;
            lastGrant <= 1'b1;
        end else if (accept) begin
            opSel     <= reqSelect;
            remaining <= reqAmount;
            work      <= reqData;
            owner     <= grant;
            lastGrant <= grant;
        end else if (state == SHIFT) begin
            work      <= ShiftedB;
            remaining <= remainingNext;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter with a behavioural barrel shifter and a whole-command reference model.
module tb_shifter_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid;
    logic        Req0Ready, Req1Ready;
    logic [2:0]  Req0Select, Req1Select;
    logic [4:0]  Req0Amount, Req1Amount;
    logic [15:0] Req0Data, Req1Data;
    logic        Rsp0Valid, Rsp1Valid;
    logic        Rsp0Ready, Rsp1Ready;
    logic [15:0] Rsp0Data, Rsp1Data;
    logic [2:0]  ShiftSelect;
    logic [3:0]  ShifterAmount;
    logic [15:0] OriginB;
    logic [15:0] ShiftedB;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    shifter_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Select(Req0Select),
        .Req0Amount(Req0Amount), .Req0Data(Req0Data),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Select(Req1Select),
        .Req1Amount(Req1Amount), .Req1Data(Req1Data),
        .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Data(Rsp0Data),
        .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Data(Rsp1Data),
        .ShiftSelect(ShiftSelect), .ShifterAmount(ShifterAmount), .OriginB(OriginB),
        .ShiftedB(ShiftedB), .Busy(Busy)
    );

    // Combinational single-pass barrel shifter (0-15 positions).
    logic [31:0] rotWide;
    always_comb begin
        rotWide = {OriginB, OriginB};
        case (ShiftSelect)
            3'd0: ShiftedB = OriginB >> ShifterAmount;
            3'd1: ShiftedB = OriginB << ShifterAmount;
            3'd2: begin rotWide = rotWide >> ShifterAmount; ShiftedB = rotWide[15:0]; end
            3'd3: begin rotWide = rotWide << ShifterAmount; ShiftedB = rotWide[31:16]; end
            3'd4: ShiftedB = 16'($signed(OriginB) >>> ShifterAmount);
            default: ShiftedB = 16'h0;
        endcase
    end

    // Whole-command result for a 0-31 shift, independent of how it is split into passes.
    function automatic logic [15:0] refShift(input logic [2:0] sel, input logic [4:0] amt,
                                             input logic [15:0] d);
        logic [31:0] w;
        int k;
        w = {d, d};
        k = int'(amt) % 16;
        case (sel)
            3'd0: return (amt >= 5'd16) ? 16'h0 : d >> amt;
            3'd1: return (amt >= 5'd16) ? 16'h0 : d << amt;
            3'd2: begin w = w >> k; return w[15:0]; end
            3'd3: begin w = w << k; return w[31:16]; end
            3'd4: return (amt >= 5'd16) ? {16{d[15]}} : 16'($signed(d) >>> amt);
            default: return (amt == 5'd0) ? d : 16'h0;
        endcase
    endfunction

    function automatic int refPassCount(input logic [4:0] amt);
        return (int'(amt) + 14) / 15;
    endfunction

    // Pass amounts packed 4 bits each, first pass in the low nibble.
    function automatic logic [15:0] refPassLog(input logic [4:0] amt);
        int rem;
        int i;
        logic [15:0] plog;
        rem = int'(amt);
        i = 0;
        plog = 16'h0;
        while (rem > 0) begin
            plog[4*i +: 4] = (rem > 15) ? 4'd15 : 4'(rem);
            rem = rem - ((rem > 15) ? 15 : rem);
            i++;
        end
        return plog;
    endfunction

    task automatic driveReq(input bit r, input logic v, input logic [2:0] sel,
                            input logic [4:0] amt, input logic [15:0] d);
        if (r) begin
            Req1Valid = v; Req1Select = sel; Req1Amount = amt; Req1Data = d;
        end else begin
            Req0Valid = v; Req0Select = sel; Req0Amount = amt; Req0Data = d;
        end
    endtask

    // Runs one command end to end and reports what was observed.
    task automatic doCommand(input bit r, input logic [2:0] sel, input logic [4:0] amt,
                             input logic [15:0] d, output logic [15:0] res, output int lat,
                             output logic [15:0] passLog, output bit readyOk,
                             output bit otherRsp, output bit timedOut);
        int cycles;
        int nPasses;
        res = 16'h0; lat = 0; passLog = 16'h0; readyOk = 1'b0; otherRsp = 1'b0; timedOut = 1'b0;
        nPasses = 0;
        @(negedge Clk);
        driveReq(r, 1'b1, sel, amt, d);
        #1;
        cycles = 0;
        while (!(r ? Req1Ready : Req0Ready) && cycles < 20) begin
            @(negedge Clk); #1; cycles++;
        end
        if (cycles >= 20) timedOut = 1'b1;
        readyOk = r ? (Req1Ready && !Req0Ready) : (Req0Ready && !Req1Ready);
        @(negedge Clk);
        driveReq(r, 1'b0, 3'd0, 5'd0, 16'h0);
        #1;
        cycles = 0;
        while (!(r ? Rsp1Valid : Rsp0Valid) && cycles < 10) begin
            if (ShifterAmount != 4'd0 && nPasses < 4) passLog[4*nPasses +: 4] = ShifterAmount;
            if (ShifterAmount != 4'd0) nPasses++;
            if (r ? Rsp0Valid : Rsp1Valid) otherRsp = 1'b1;
            @(negedge Clk); #1; cycles++;
        end
        if (cycles >= 10) timedOut = 1'b1;
        if (r ? Rsp0Valid : Rsp1Valid) otherRsp = 1'b1;
        lat = cycles;
        res = r ? Rsp1Data : Rsp0Data;
        if (r) Rsp1Ready = 1'b1; else Rsp0Ready = 1'b1;
        @(negedge Clk);
        Rsp0Ready = 1'b0;
        Rsp1Ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b1;
        driveReq(0, 1'b1, 3'd1, 5'd3, 16'h1111);
        driveReq(1, 1'b1, 3'd1, 5'd3, 16'h2222);
        repeat (2) @(negedge Clk);
        #1;
        checks++;
        if ({Req0Ready, Req1Ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", {Req0Ready, Req1Ready});
        end
        checks++;
        if ({Busy, Rsp0Valid, Rsp1Valid, Rsp0Data, Rsp1Data, ShiftSelect, ShifterAmount, OriginB} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b rv=%b%b rd=%h/%h sel=%h amt=%h ob=%h want all 0",
                     Busy, Rsp0Valid, Rsp1Valid, Rsp0Data, Rsp1Data, ShiftSelect, ShifterAmount, OriginB);
        end
        @(negedge Clk);
        Reset = 1'b0;
        driveReq(0, 1'b0, 3'd0, 5'd0, 16'h0);
        driveReq(1, 1'b0, 3'd0, 5'd0, 16'h0);
        @(negedge Clk); #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy got %b want 0", Busy);
        end
    endtask

    task automatic test_sll();
        logic [15:0] res, plog;
        int lat;
        bit rdy, oth, to;
        doCommand(1'b0, 3'd1, 5'd4, 16'h00F1, res, lat, plog, rdy, oth, to);
        checks++;
        if (res !== 16'h0F10) begin errors++; $display("FAIL sll_result got %h want 0f10", res); end
        checks++;
        if (lat !== 1 || plog !== 16'h0004) begin
            errors++; $display("FAIL sll_passes got lat=%0d log=%h want 1/0004", lat, plog);
        end
        checks++;
        if ({rdy, oth, to} !== 3'b100) begin
            errors++; $display("FAIL sll_handshake got rdy=%b other=%b timeout=%b want 1/0/0", rdy, oth, to);
        end
    endtask

    task automatic test_sra_srl();
        logic [15:0] res, plog;
        int lat;
        bit rdy, oth, to;
        doCommand(1'b1, 3'd4, 5'd20, 16'h8000, res, lat, plog, rdy, oth, to);
        checks++;
        if (res !== 16'hFFFF) begin errors++; $display("FAIL sra20_result got %h want ffff", res); end
        checks++;
        if (lat !== 2 || plog !== 16'h005F || {rdy, oth, to} !== 3'b100) begin
            errors++;
            $display("FAIL sra20_passes got lat=%0d log=%h rdy=%b oth=%b to=%b want 2/005f/1/0/0",
                     lat, plog, rdy, oth, to);
        end
        doCommand(1'b1, 3'd0, 5'd20, 16'h8000, res, lat, plog, rdy, oth, to);
        checks++;
        if (res !== 16'h0000 || to) begin
            errors++; $display("FAIL srl20_result got %h timeout=%b want 0000", res, to);
        end
    endtask

    task automatic test_rol_and_zero();
        logic [15:0] res, plog;
        int lat;
        bit rdy, oth, to;
        doCommand(1'b0, 3'd3, 5'd31, 16'h0001, res, lat, plog, rdy, oth, to);
        checks++;
        if (res !== 16'h8000) begin errors++; $display("FAIL rol31_result got %h want 8000", res); end
        checks++;
        if (lat !== 3 || plog !== 16'h01FF || to) begin
            errors++; $display("FAIL rol31_passes got lat=%0d log=%h want 3/01ff", lat, plog);
        end
        doCommand(1'b1, 3'd0, 5'd0, 16'hABCD, res, lat, plog, rdy, oth, to);
        checks++;
        if (res !== 16'hABCD || lat !== 0 || plog !== 16'h0 || to) begin
            errors++; $display("FAIL amount0 got res=%h lat=%0d log=%h want abcd/0/0000", res, lat, plog);
        end
    endtask

    task automatic test_random();
        logic [15:0] res, plog, d;
        logic [2:0] sel;
        logic [4:0] amt;
        int lat;
        bit r, rdy, oth, to;
        for (int i = 0; i < 24; i++) begin
            r   = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            amt = 5'($urandom_range(0, 31));
            d   = 16'($urandom);
            doCommand(r, sel, amt, d, res, lat, plog, rdy, oth, to);
            checks++;
            if (res !== refShift(sel, amt, d)) begin
                errors++;
                $display("FAIL rand_result req=%0d sel=%0d amt=%0d d=%h got %h want %h",
                         r, sel, amt, d, res, refShift(sel, amt, d));
            end
            checks++;
            if (lat !== refPassCount(amt) || plog !== refPassLog(amt) || {rdy, oth, to} !== 3'b100) begin
                errors++;
                $display("FAIL rand_seq amt=%0d got lat=%0d log=%h flags=%b want %0d/%h/100",
                         amt, lat, plog, {rdy, oth, to}, refPassCount(amt), refPassLog(amt));
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] got;
        logic [3:0] expGrants;
        int ng;
        int cycles;
        bit both;
`ifdef SHIFTER_ARB_FIXED_PRIORITY_EN
        expGrants = 4'b0000;
`else
        expGrants = 4'b1010;
`endif
        got = 4'b0; ng = 0; both = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;
        driveReq(0, 1'b1, 3'd1, 5'd1, 16'h0101);
        driveReq(1, 1'b1, 3'd1, 5'd1, 16'h0202);
        cycles = 0;
        #1;
        while (ng < 4 && cycles < 60) begin
            if (Req0Ready && Req1Ready) both = 1'b1;
            if (Req0Ready || Req1Ready) begin
                got[ng] = Req1Ready;
                ng++;
            end
            @(negedge Clk); #1; cycles++;
        end
        driveReq(0, 1'b0, 3'd0, 5'd0, 16'h0);
        driveReq(1, 1'b0, 3'd0, 5'd0, 16'h0);
        repeat (4) @(negedge Clk);
        Rsp0Ready = 1'b0; Rsp1Ready = 1'b0;
        checks++;
        if (ng !== 4 || got !== expGrants) begin
            errors++; $display("FAIL arb_order got n=%0d grants(lsb first)=%b want 4/%b", ng, got, expGrants);
        end
        checks++;
        if (both !== 1'b0) begin errors++; $display("FAIL arb_both_ready got 1 want 0"); end
    endtask

    task automatic test_resp_hold();
        logic [15:0] expRes;
        int cycles;
        bit bad;
        expRes = refShift(3'd2, 5'd3, 16'h1234);
        bad = 1'b0;
        @(negedge Clk);
        driveReq(0, 1'b1, 3'd2, 5'd3, 16'h1234);
        #1;
        cycles = 0;
        while (!Req0Ready && cycles < 20) begin @(negedge Clk); #1; cycles++; end
        @(negedge Clk);
        driveReq(0, 1'b0, 3'd0, 5'd0, 16'h0);
        #1;
        while (!Rsp0Valid && cycles < 40) begin @(negedge Clk); #1; cycles++; end
        checks++;
        if (cycles >= 40) begin errors++; $display("FAIL hold_timeout got no Rsp0Valid want response"); end
        driveReq(0, 1'b1, 3'd1, 5'd1, 16'h5555);
        driveReq(1, 1'b1, 3'd1, 5'd1, 16'h6666);
        Rsp1Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({Rsp0Valid, Rsp1Valid, Req0Ready, Req1Ready, Busy} !== 5'b10001 || Rsp0Data !== expRes) begin
                errors++;
                $display("FAIL hold_cycle%0d got flags=%b data=%h want 10001/%h",
                         i, {Rsp0Valid, Rsp1Valid, Req0Ready, Req1Ready, Busy}, Rsp0Data, expRes);
                bad = 1'b1;
            end
            @(negedge Clk);
        end
        driveReq(0, 1'b0, 3'd0, 5'd0, 16'h0);
        driveReq(1, 1'b0, 3'd0, 5'd0, 16'h0);
        Rsp1Ready = 1'b0;
        Rsp0Ready = 1'b1;
        @(negedge Clk);
        Rsp0Ready = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || Rsp0Valid !== 1'b0) begin
            errors++; $display("FAIL hold_release got busy=%b rv=%b want 0/0", Busy, Rsp0Valid);
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        bit seen;
        @(negedge Clk);
        driveReq(0, 1'b1, 3'd3, 5'd31, 16'h0001);
        #1;
        cycles = 0;
        while (!Req0Ready && cycles < 20) begin @(negedge Clk); #1; cycles++; end
        @(negedge Clk);
        driveReq(0, 1'b0, 3'd0, 5'd0, 16'h0);
        #1;
        checks++;
        if (ShifterAmount !== 4'd15 || Busy !== 1'b1) begin
            errors++; $display("FAIL midrst_pass1 got amt=%0d busy=%b want 15/1", ShifterAmount, Busy);
        end
        @(negedge Clk); #1;
        checks++;
        if (ShifterAmount !== 4'd15 || OriginB !== 16'h8000) begin
            errors++; $display("FAIL midrst_pass2 got amt=%0d ob=%h want 15/8000", ShifterAmount, OriginB);
        end
        Reset = 1'b1;
        driveReq(1, 1'b1, 3'd0, 5'd2, 16'h00FF);
        @(negedge Clk); #1;
        checks++;
        if ({Busy, Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, Rsp0Data, Rsp1Data,
             ShiftSelect, ShifterAmount, OriginB} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got busy=%b rdy=%b%b rv=%b%b rd=%h/%h sel=%h amt=%h ob=%h want all 0",
                     Busy, Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, Rsp0Data, Rsp1Data,
                     ShiftSelect, ShifterAmount, OriginB);
        end
        Reset = 1'b0;
        driveReq(1, 1'b0, 3'd0, 5'd0, 16'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge Clk); #1;
            if (Rsp0Valid || Rsp1Valid || Busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_response got activity want none"); end
    endtask

    initial begin
        Reset = 1'b1;
        Rsp0Ready = 1'b0;
        Rsp1Ready = 1'b0;
        driveReq(0, 1'b0, 3'd0, 5'd0, 16'h0);
        driveReq(1, 1'b0, 3'd0, 5'd0, 16'h0);
        test_reset();
        test_sll();
        test_sra_srl();
        test_rol_and_zero();
        test_random();
        test_round_robin();
        test_resp_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_arbiter.md
# shifter_arbiter

Two-requester arbiter and pass sequencer for the shared 16-bit `BarrelShifter`. Accepts shift commands with 5-bit amounts (0–31) from two independent requesters. Grants one command at a time and splits its amount into one or more shifter passes of at most 15 positions each. Returns the result on the winning requester's response channel. Sits between the control-unit-side requesters and the single combinational shifter instance in the datapath.

## Interface
- No parameters; widths are fixed (data 16, select 3, amount 5).
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Req0Valid` / `Req1Valid`  in  1  command present.
- `Req0Ready` / `Req1Ready`  out  1  command accepted this cycle when ready and valid are both high.
- `Req0Select` / `Req1Select`  in  3  shift op: 000 SRL, 001 SLL, 010 ROR, 011 ROL, 100 SRA, others undefined.
- `Req0Amount` / `Req1Amount`  in  5  total shift distance, 0–31.
- `Req0Data` / `Req1Data`  in  16  operand.
- `Rsp0Valid` / `Rsp1Valid`  out  1  result available.
- `Rsp0Ready` / `Rsp1Ready`  in  1  result consumed.
- `Rsp0Data` / `Rsp1Data`  out  16  result.
- `ShiftSelect`  out  3  to shifter.
- `ShifterAmount`  out  4  to shifter.
- `OriginB`  out  16  to shifter.
- `ShiftedB`  in  16  from shifter; combinational in the same cycle.
- `Busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, SHIFT and RESP.
- Internal registers:
  - `OpSel[2:0]`, the latched select.
  - `Remaining[4:0]`, the distance still to shift.
  - `Work[15:0]`, the working data.
  - `Owner`, the granted requester.
  - `LastGrant`, the round-robin pointer.
- IDLE:
  - If exactly one `ReqNValid` is high, grant it.
  - If both are high, grant the requester that is not `LastGrant`.
  - The granted `ReqNReady` is driven combinationally high in IDLE only. The other ready stays low.
  - On acceptance, latch select, amount and data, set `Owner`, and set `LastGrant` to `Owner`.
  - If the amount is 0, go to RESP with `Work` equal to the operand. Otherwise go to SHIFT.
- SHIFT:
  - Drive `ShiftSelect=OpSel`, `OriginB=Work`, and `ShifterAmount=min(Remaining,15)`.
  - On each edge, `Work<=ShiftedB` and `Remaining<=Remaining-step`.
  - When the new `Remaining` is 0, go to RESP.
- Pass count is ceil(amount/15): 1–15 takes 1 pass, 16–30 takes 2 passes, 31 takes 3 passes (15, 15, 1).
- Composition: repeated passes are exact for all five defined ops.
  - SRL and SLL by 16 or more yields 0.
  - SRA by 16 or more yields all sign bits.
  - ROR and ROL act modulo 16.
- Undefined selects (101–111) are sequenced normally. The result is whatever the shifter returns, which is 0.
- RESP:
  - `RspNValid` is high for `Owner` only, with `RspNData=Work`, held stable until `RspNReady`.
  - On `RspNReady`, go to IDLE.
  - The non-owner response channel stays low. `RspNReady` on the non-owner is ignored.
- Outside SHIFT, the shifter-side outputs are `ShiftSelect=0`, `ShifterAmount=0` and `OriginB=0`.

## Timing
- Reset takes priority over everything and takes effect at the next edge. After it:
  - the state is IDLE and `LastGrant=1`, so requester 0 wins the first tie;
  - `Work=0`, `Remaining=0`, `OpSel=0`, `Owner=0`;
  - all Ready, Rsp*Valid, `Busy` and shifter-side outputs are 0, and `Rsp*Data=0`.
- While `Reset` is high, both `ReqNReady` are forced low.
- Reset asserted in SHIFT or RESP abandons the operation. No response is issued.
- Latency from the accept edge to `RspNValid` high is P cycles for P passes, or 0 extra cycles for amount 0 (RESP is entered on the accept edge).
- Minimum occupancy per command is 1 IDLE cycle + P SHIFT cycles + at least 1 RESP cycle. Back-to-back accepts are at least P+2 cycles apart.
- A requester that loses arbitration keeps its command valid. It wins the next IDLE cycle if the winner does not re-request; otherwise it wins by round-robin.
- `ReqNReady` depends combinationally on `ReqNValid`. `RspNValid` does not depend on `RspNReady`.

## Configuration
- `SHIFTER_ARB_FIXED_PRIORITY_EN`:
  - When defined, requester 0 always wins when both are valid. `LastGrant` is still updated but ignored.
  - When undefined, the round-robin rule above applies.

## Test plan
- Reset, then requester 0 sends SLL, amount 4, data 16'h00F1. Require `Req0Ready` high for one cycle, SHIFT for 1 cycle, `Rsp0Valid` with 16'h0F10, and `Rsp1Valid` low throughout.
- Requester 1 sends SRA, amount 20, data 16'h8000. Require two passes (`ShifterAmount` 15 then 5) and result 16'hFFFF. SRL with the same inputs gives 16'h0000.
- ROL, amount 31, data 16'h0001: require passes 15, 15, 1 and result 16'h8000. Amount 0 with data 16'hABCD must respond with 16'hABCD with no SHIFT cycle.
- Both requesters valid every cycle with `RspNReady` tied high. Require grants alternating 0,1,0,1. With `SHIFTER_ARB_FIXED_PRIORITY_EN` defined, require 0,0,0.
- Hold `Rsp0Ready` low for 5 cycles in RESP. Require `Rsp0Data` stable, both `ReqNReady` low and `Busy` high until release.
- Assert `Reset` during the second pass of an amount-31 command. Next cycle, require IDLE, no response, and all outputs at reset values.
